ff_readout_sched: RTL

- Round-robin scheduler that drains the seven external event FIFOs (FIFO 1..7) one packet at a time onto a single 19-bit output stream.
- Sits between the FIFO enable register / FIFO read strobes and the downstream packer.
- A packet ends on the LAST bit (FF_RD_DATA[16]) or on the word limit. FF_RD_DATA[17] is OVLP and bit 18 is reserved; both pass through unchanged.

---
 rtl/ff_readout_sched.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/ff_readout_sched.sv
// Round-robin drain of event FIFOs 1..7 onto one 19-bit stream, one packet per grant.
// Optional stall timeout compiled in with `define FF_SCHED_TMO_EN.
module ff_readout_sched #(
  parameter int RD_LAT    = 2,
  parameter int MAX_WORDS = 4095,
  parameter int TMO_CYC   = 1023
) (
  input  logic        FASTCLK,
  input  logic        RST_B,
  input  logic [6:0]  ENAFF,
  input  logic [6:0]  FF_MT,
  input  logic [18:0] FF_RD_DATA,
  input  logic        HALT,
  input  logic        DOUT_READY,
  output logic [6:0]  FF_REN,
  output logic [2:0]  FF_SEL,
  output logic [18:0] DOUT,
  output logic [2:0]  DOUT_SRC,
  output logic        DOUT_VALID,
  output logic        PKT_DONE,
  output logic        BUSY,
  output logic [11:0] WORD_CNT,
  output logic        ERR_TRUNC,
  output logic        ERR_TMO,
  output logic [2:0]  dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ARB   = 3'd1,
    S_RDSTB = 3'd2,
    S_WAIT  = 3'd3,
    S_HOLD  = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t      state;
  logic [2:0]  ptr;
  logic [2:0]  lat_cnt;
  logic [2:0]  grant;
  logic [3:0]  idx;
  logic [6:0]  cand;
  logic [7:0]  sel_dec;
  logic [6:0]  sel_mask;
  logic        sel_empty;
  logic        last_word;
  logic [11:0] cnt_next;

  assign cand      = ENAFF & ~FF_MT;
  assign sel_dec   = 8'd1 << FF_SEL;
  assign sel_mask  = sel_dec[7:1];
  assign sel_empty = |(FF_MT & sel_mask);
  assign last_word = DOUT[16];
  assign cnt_next  = WORD_CNT + 12'd1;
  assign BUSY      = (state != S_IDLE);
  assign dbg_state = state;

  // Strobe is decoded from the state so it can only be high during RDSTB.
  assign FF_REN = (state == S_RDSTB && !sel_empty) ? sel_mask : 7'd0;

  // First candidate strictly after ptr, circular 7 -> 1; lowest k wins.
  always_comb begin
    grant = 3'd0;
    idx   = 4'd0;
    for (int k = 7; k >= 1; k--) begin
      idx = {1'b0, ptr} + 4'(k);
      if (idx > 4'd7) idx = idx - 4'd7;
      if (cand[idx[2:0] - 3'd1]) grant = idx[2:0];
    end
  end

`ifdef FF_SCHED_TMO_EN
  logic [15:0] tmo_cnt;
`else
  wire unused_tmo = ^TMO_CYC;
  assign ERR_TMO = 1'b0;
`endif

  // Output handshake: a word transfers on a cycle where DOUT_VALID and
  // DOUT_READY are both high; DOUT/DOUT_VALID are held until that happens.
  always_ff @(posedge FASTCLK or negedge RST_B) begin
    if (!RST_B) begin
      state      <= S_IDLE;
      ptr        <= 3'd7;
      lat_cnt    <= 3'd0;
      FF_SEL     <= 3'd0;
      DOUT       <= 19'd0;
      DOUT_SRC   <= 3'd0;
      DOUT_VALID <= 1'b0;
      PKT_DONE   <= 1'b0;
      WORD_CNT   <= 12'd0;
      ERR_TRUNC  <= 1'b0;
`ifdef FF_SCHED_TMO_EN
      ERR_TMO    <= 1'b0;
      tmo_cnt    <= 16'd0;
`endif
    end else begin
      PKT_DONE  <= 1'b0;
      ERR_TRUNC <= 1'b0;
`ifdef FF_SCHED_TMO_EN
      ERR_TMO   <= 1'b0;
`endif
      case (state)
        S_IDLE: begin
          if (!HALT && cand != 7'd0) state <= S_ARB;
        end
        S_ARB: begin
          if (cand == 7'd0) begin
            state <= S_IDLE;
          end else begin
            FF_SEL <= grant;
            state  <= S_RDSTB;
          end
        end
        S_RDSTB: begin
          if (!sel_empty) begin
            lat_cnt <= 3'(RD_LAT);
            state   <= S_WAIT;
`ifdef FF_SCHED_TMO_EN
            tmo_cnt <= 16'd0;
          end else if (tmo_cnt == 16'(TMO_CYC - 1)) begin
            ERR_TMO  <= 1'b1;
            PKT_DONE <= 1'b1;
            tmo_cnt  <= 16'd0;
            state    <= S_DONE;
          end else begin
            tmo_cnt <= tmo_cnt + 16'd1;
`endif
          end
        end
        S_WAIT: begin
          if (lat_cnt == 3'd1) begin
            DOUT       <= FF_RD_DATA;
            DOUT_SRC   <= FF_SEL;
            DOUT_VALID <= 1'b1;
            state      <= S_HOLD;
          end else begin
            lat_cnt <= lat_cnt - 3'd1;
          end
        end
        S_HOLD: begin
          if (DOUT_READY) begin
            DOUT_VALID <= 1'b0;
            WORD_CNT   <= cnt_next;
            // LAST takes precedence over the limit, so truncation needs LAST low.
            if (last_word || cnt_next == 12'(MAX_WORDS)) begin
              PKT_DONE  <= 1'b1;
              ERR_TRUNC <= !last_word;
              state     <= S_DONE;
            end else begin
              state <= S_RDSTB;
            end
          end
        end
        S_DONE: begin
          ptr      <= FF_SEL;
          FF_SEL   <= 3'd0;
          WORD_CNT <= 12'd0;
          state    <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
